// File: rtl/taxi_meter_ctrl_if.sv
// Signal bundle between the taxi trip controller and the rest of the fare datapath.
// The master side drives the buttons and sensors, and the slave side is the controller.
interface taxi_meter_ctrl_if;
  logic        tick_1hz;
  logic        wheel_pulse;
  logic        start_btn;
  logic        stop_btn;
  logic        clear_btn;
  logic        night_in;
  logic        max;
  logic        run_en;
  logic        wait_en;
  logic        fare_clr;
  logic        trip_done;
  logic [1:0]  state;
  logic [11:0] wait_fare_per_unit;

  modport master (
    output tick_1hz, wheel_pulse, start_btn, stop_btn, clear_btn, night_in, max,
    input  run_en, wait_en, fare_clr, trip_done, state, wait_fare_per_unit
  );

  modport slave (
    input  tick_1hz, wheel_pulse, start_btn, stop_btn, clear_btn, night_in, max,
    output run_en, wait_en, fare_clr, trip_done, state, wait_fare_per_unit
  );
endinterface

// File: rtl/taxi_meter_ctrl.sv
// Trip sequencer for the taxi meter: IDLE -> DRIVE <-> WAIT -> DONE, with accumulator enables and clear.
// Optional macro NIGHT_RATE_EN selects the night waiting rate from night_in at trip start.
module taxi_meter_ctrl #(
  parameter int          STOP_TIMEOUT    = 10,
  parameter logic [11:0] DAY_WAIT_RATE   = 12'h050,
  parameter logic [11:0] NIGHT_WAIT_RATE = 12'h075
) (
  input  logic              clk,
  input  logic              rst,
  taxi_meter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int                CNT_W    = $clog2(STOP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STOP_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fare_clr_q, fare_clr_d;
  logic               latch_rate;
  logic               start_h, stop_h, clear_h;
  logic               start_ev, stop_ev, clear_ev;

  assign start_ev = bus.start_btn & ~start_h;
  assign stop_ev  = bus.stop_btn  & ~stop_h;
  assign clear_ev = bus.clear_btn & ~clear_h;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fare_clr_q <= 1'b0;
      // A button held through reset must not look like a fresh press.
      start_h    <= 1'b1;
      stop_h     <= 1'b1;
      clear_h    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fare_clr_q <= fare_clr_d;
      start_h    <= bus.start_btn;
      stop_h     <= bus.stop_btn;
      clear_h    <= bus.clear_btn;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fare_clr_d = 1'b0;
    latch_rate = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_ev) begin
          state_d    = DRIVE;
          fare_clr_d = 1'b1;
          latch_rate = 1'b1;
        end
      end
      DRIVE: begin
        if (stop_ev || bus.max) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (bus.wheel_pulse) begin
          cnt_d = '0;
        end else if (bus.tick_1hz) begin
          if (cnt_q == CNT_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        cnt_d = '0;
        if (stop_ev || bus.max) state_d = DONE;
        else if (bus.wheel_pulse) state_d = DRIVE;
      end
      DONE: begin
        cnt_d = '0;
        // Clear outranks start when both buttons rise together.
        if (clear_ev) begin
          state_d    = IDLE;
          fare_clr_d = 1'b1;
        end else if (start_ev) begin
          state_d    = DRIVE;
          fare_clr_d = 1'b1;
          latch_rate = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.run_en    = (state_q == DRIVE);
  assign bus.wait_en   = (state_q == WAIT);
  assign bus.trip_done = (state_q == DONE);
  assign bus.fare_clr  = fare_clr_q;

`ifdef NIGHT_RATE_EN
  logic [11:0] rate_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rate_q <= DAY_WAIT_RATE;
    else if (latch_rate) rate_q <= bus.night_in ? NIGHT_WAIT_RATE : DAY_WAIT_RATE;
  end

  assign bus.wait_fare_per_unit = rate_q;
`else
  logic [13:0] unused_rate_bits;
  assign unused_rate_bits       = {bus.night_in, latch_rate, NIGHT_WAIT_RATE};
  assign bus.wait_fare_per_unit = DAY_WAIT_RATE;
`endif

endmodule

// File: tb/tb_taxi_meter_ctrl.sv
// Directed bench for taxi_meter_ctrl: a vector table for the main trip flow plus hand sequences
// for the timeout, priority and asynchronous-reset corner cases.
module tb_taxi_meter_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00, S_DRIVE = 2'b01, S_WAIT = 2'b10, S_DONE = 2'b11;
  localparam logic [11:0] DAY = 12'h050;
`ifdef NIGHT_RATE_EN
  localparam logic [11:0] NR = 12'h075;
`else
  localparam logic [11:0] NR = 12'h050;
`endif

  // in  = {start, stop, clear, wheel, tick, max, night}
  // out = {run_en, wait_en, fare_clr, trip_done}
  typedef struct {
    logic [6:0]  in;
    logic [1:0]  st;
    logic [3:0]  out;
    logic [11:0] rate;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  taxi_meter_ctrl_if bus ();

  taxi_meter_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [6:0] in, input logic [1:0] st,
                              input logic [3:0] out, input logic [11:0] rate);
    vec_t v;
    v.in = in; v.st = st; v.out = out; v.rate = rate;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".state"},     32'(bus.state),              32'(v.st));
    check({tag, ".run_en"},    32'(bus.run_en),             32'(v.out[3]));
    check({tag, ".wait_en"},   32'(bus.wait_en),            32'(v.out[2]));
    check({tag, ".fare_clr"},  32'(bus.fare_clr),           32'(v.out[1]));
    check({tag, ".trip_done"}, 32'(bus.trip_done),          32'(v.out[0]));
    check({tag, ".rate"},      32'(bus.wait_fare_per_unit), 32'(v.rate));
  endtask

  // Drive one cycle of inputs, let one clock edge pass, then compare just after it.
  task automatic apply(input vec_t v, input string tag);
    {bus.start_btn, bus.stop_btn, bus.clear_btn, bus.wheel_pulse,
     bus.tick_1hz, bus.max, bus.night_in} = v.in;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  // Tick pulses separated by quiet cycles, expecting the meter to stay in st throughout.
  task automatic ticks(input int n, input logic [1:0] st, input logic [3:0] out,
                       input logic [11:0] rate, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(mk(7'b0000100, st, out, rate), $sformatf("%s_t%0d", tag, i));
      apply(mk(7'b0000000, st, out, rate), $sformatf("%s_q%0d", tag, i));
    end
  endtask

  vec_t tbl [15];

  initial begin
    tbl[0]  = mk(7'b1000000, S_IDLE,  4'b0000, DAY);  // start still held from reset: no edge
    tbl[1]  = mk(7'b0000000, S_IDLE,  4'b0000, DAY);
    tbl[2]  = mk(7'b1000001, S_DRIVE, 4'b1010, NR);   // press with night switch on
    tbl[3]  = mk(7'b1000001, S_DRIVE, 4'b1000, NR);
    tbl[4]  = mk(7'b0000000, S_DRIVE, 4'b1000, NR);   // night drops mid-trip
    tbl[5]  = mk(7'b0001000, S_DRIVE, 4'b1000, NR);
    tbl[6]  = mk(7'b0100000, S_DONE,  4'b0001, NR);
    tbl[7]  = mk(7'b0000000, S_DONE,  4'b0001, NR);
    tbl[8]  = mk(7'b1000000, S_DRIVE, 4'b1010, DAY);  // restart re-latches the day rate
    tbl[9]  = mk(7'b0000000, S_DRIVE, 4'b1000, DAY);
    tbl[10] = mk(7'b0000010, S_DONE,  4'b0001, DAY);  // saturation freezes the meter
    tbl[11] = mk(7'b0010000, S_IDLE,  4'b0010, DAY);
    tbl[12] = mk(7'b0000000, S_IDLE,  4'b0000, DAY);
    tbl[13] = mk(7'b0111110, S_IDLE,  4'b0000, DAY);  // everything but start ignored in IDLE
    tbl[14] = mk(7'b0000000, S_IDLE,  4'b0000, DAY);

    {bus.start_btn, bus.stop_btn, bus.clear_btn, bus.wheel_pulse,
     bus.tick_1hz, bus.max, bus.night_in} = 7'b1000000;
    repeat (3) @(posedge clk);
    #1;
    check_outs("in_reset", mk(7'b0, S_IDLE, 4'b0000, DAY));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout into WAIT and wheel back to DRIVE.
    apply(mk(7'b1000000, S_DRIVE, 4'b1010, DAY), "hs_start");
    apply(mk(7'b0000000, S_DRIVE, 4'b1000, DAY), "hs_rel");
    ticks(9, S_DRIVE, 4'b1000, DAY, "hs_a");
    apply(mk(7'b0000100, S_WAIT,  4'b0100, DAY), "hs_to_wait");
    ticks(3, S_WAIT, 4'b0100, DAY, "hs_wait_ticks");
    apply(mk(7'b0001000, S_DRIVE, 4'b1000, DAY), "hs_wheel_back");

    // Wheel and tick together restart the count; a start press in DRIVE is ignored.
    ticks(9, S_DRIVE, 4'b1000, DAY, "hs_b");
    apply(mk(7'b1000000, S_DRIVE, 4'b1000, DAY), "hs_start_in_drive");
    apply(mk(7'b0000000, S_DRIVE, 4'b1000, DAY), "hs_start_rel");
    apply(mk(7'b0001100, S_DRIVE, 4'b1000, DAY), "hs_wheel_tick");
    ticks(9, S_DRIVE, 4'b1000, DAY, "hs_c");
    apply(mk(7'b0000100, S_WAIT,  4'b0100, DAY), "hs_to_wait2");

    // Saturation in WAIT, then clear and start together.
    apply(mk(7'b0000010, S_DONE,  4'b0001, DAY), "hs_max_wait");
    apply(mk(7'b0000010, S_DONE,  4'b0001, DAY), "hs_max_done");
    apply(mk(7'b1010000, S_IDLE,  4'b0010, DAY), "hs_clr_start");
    apply(mk(7'b0000000, S_IDLE,  4'b0000, DAY), "hs_idle");

    // Reset mid-WAIT must take effect before the next clock edge.
    apply(mk(7'b1000000, S_DRIVE, 4'b1010, DAY), "hs_start3");
    apply(mk(7'b0000000, S_DRIVE, 4'b1000, DAY), "hs_rel3");
    ticks(9, S_DRIVE, 4'b1000, DAY, "hs_d");
    apply(mk(7'b0000100, S_WAIT,  4'b0100, DAY), "hs_to_wait3");
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", mk(7'b0, S_IDLE, 4'b0000, DAY));
    @(negedge clk);
    rst = 1'b0;
    apply(mk(7'b0000000, S_IDLE, 4'b0000, DAY), "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
